// File: rtl/spi_flash_burst_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_burst_reader
//   Reads BURST_BYTES from a 24-bit flash address (SPI mode 0) on a start
//   pulse and streams the bytes out over a valid/ready byte interface.
//   Backpressure stalls SCK low ahead of the final rising edge of a byte, so
//   a completed byte is never overwritten before it is accepted.
//
//   Optional feature macro: SPI_FAST_READ_EN
//     defined   -> command 0x0B followed by 8 dummy SCK cycles
//     undefined -> command 0x03, no dummy cycles
//
// Ports
//   clk_i          system clock
//   rst_n_i        synchronous reset, active low
//   start_i        1-cycle burst request, honoured only while ready_o=1
//   start_addr_i   first byte address, captured with start_i
//   ready_o        idle and able to accept start_i
//   next_addr_o    start_addr + BURST_BYTES (mod 2^24), updated at burst end
//   out_data_o     received byte (MSB first)
//   out_valid_o    out_data_o valid, held until out_ready_i
//   out_ready_i    consumer accepts byte when out_valid_o && out_ready_i
//   out_last_o     marks the final byte of the burst
//   flash_clk_o    SPI SCK, idles low
//   flash_mosi_o   SPI MOSI
//   flash_miso_i   SPI MISO
//   flash_cs_n_o   SPI chip select, active low
// ---------------------------------------------------------------------------
module spi_flash_burst_reader #(
   parameter int STARTUP_WAIT = 10000000,
   parameter int CLK_DIV      = 1,
   parameter int BURST_BYTES  = 32
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [23:0] start_addr_i,
   output logic        ready_o,
   output logic [23:0] next_addr_o,
   output logic [7:0]  out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        out_last_o,
   output logic        flash_clk_o,
   output logic        flash_mosi_o,
   input  logic        flash_miso_i,
   output logic        flash_cs_n_o
);

`ifdef SPI_FAST_READ_EN
   localparam logic [7:0] CMD = 8'h0B;
`else
   localparam logic [7:0] CMD = 8'h03;
`endif

   localparam int INIT_W = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
   localparam int DIV_W  = $clog2(2*CLK_DIV);
   localparam int BYTE_W = (BURST_BYTES > 1) ? $clog2(BURST_BYTES) : 1;

   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'((STARTUP_WAIT > 0) ? STARTUP_WAIT-1 : 0);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV-1);
   localparam logic [DIV_W-1:0]  HOLD_LAST = DIV_W'(2*CLK_DIV-1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BURST_BYTES-1);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
   } state_t;

`ifdef SPI_FAST_READ_EN
   localparam state_t AFTER_ADDR = S_DUMMY;
`else
   localparam state_t AFTER_ADDR = S_DATA;
`endif

   state_t             state_q, state_d;
   logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               sck_q, sck_d;
   logic               cs_n_q, cs_n_d;
   logic [31:0]        tx_q, tx_d;       // {cmd, addr}; bit 31 drives MOSI
   logic [6:0]         rx_q, rx_d;       // first 7 bits of the byte in flight
   logic [4:0]         bit_q, bit_d;
   logic [BYTE_W-1:0]  byte_q, byte_d;
   logic [23:0]        addr_q, addr_d;
   logic [23:0]        next_addr_q, next_addr_d;
   logic [7:0]         data_q, data_d;
   logic               valid_q, valid_d;
   logic               last_q, last_d;
   logic               hold_q, hold_d;   // DONE: last byte gone, CS high timing
   logic               tick, stall;

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      div_d       = div_q;
      sck_d       = sck_q;
      cs_n_d      = cs_n_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_d       = bit_q;
      byte_d      = byte_q;
      addr_d      = addr_q;
      next_addr_d = next_addr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      last_d      = last_q;
      hold_d      = hold_q;
      tick        = (div_q == DIV_LAST);
      // Hold SCK low before the byte-completing rising edge while the
      // previous byte is still waiting for the consumer.
      stall       = !sck_q && (bit_q[2:0] == 3'd7) && valid_q && !out_ready_i;

      // Consumer handshake; a byte completing this cycle overrides below.
      if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end

      case (state_q)
         S_INIT: begin
            if (init_cnt_q == INIT_LAST) state_d = S_IDLE;
            else                         init_cnt_d = init_cnt_q + INIT_W'(1);
         end
         S_IDLE: begin
            if (start_i) begin
               addr_d  = start_addr_i;
               tx_d    = {CMD, start_addr_i};
               cs_n_d  = 1'b0;
               sck_d   = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               byte_d  = '0;
               state_d = S_CMD;
            end
         end
         S_CMD, S_ADDR, S_DUMMY: begin
            if (tick) begin
               div_d = '0;
               sck_d = ~sck_q;
               if (sck_q) begin
                  // Falling edge ends a bit; MOSI advances while SCK goes low.
                  bit_d = bit_q + 5'd1;
                  tx_d  = {tx_q[30:0], 1'b0};
                  if (state_q == S_CMD && bit_q == 5'd7) begin
                     state_d = S_ADDR;
                  end else if (state_q == S_ADDR && bit_q == 5'd31) begin
                     bit_d   = '0;
                     state_d = AFTER_ADDR;
                  end else if (state_q == S_DUMMY && bit_q == 5'd7) begin
                     bit_d   = '0;
                     state_d = S_DATA;
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_DATA: begin
            if (!tick) begin
               div_d = div_q + DIV_W'(1);
            end else if (!stall) begin
               div_d = '0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d = {rx_q[5:0], flash_miso_i};
                  if (bit_q[2:0] == 3'd7) begin
                     data_d  = {rx_q, flash_miso_i};
                     valid_d = 1'b1;
                     byte_d  = byte_q + BYTE_W'(1);
                     if (byte_q == BYTE_LAST) begin
                        // Final byte: no further SCK edges, wait for accept.
                        last_d  = 1'b1;
                        div_d   = '0;
                        hold_d  = 1'b0;
                        state_d = S_DONE;
                     end
                  end
               end else begin
                  bit_d = bit_q + 5'd1;
               end
            end
         end
         S_DONE: begin
            if (!hold_q) begin
               if (!valid_q || out_ready_i) begin
                  cs_n_d      = 1'b1;
                  sck_d       = 1'b0;
                  next_addr_d = addr_q + 24'(BURST_BYTES);
                  hold_d      = 1'b1;
                  div_d       = '0;
               end
            end else if (div_q == HOLD_LAST) begin
               hold_d  = 1'b0;
               div_d   = '0;
               state_d = S_IDLE;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_INIT;
         init_cnt_q  <= '0;
         div_q       <= '0;
         sck_q       <= 1'b0;
         cs_n_q      <= 1'b1;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_q       <= '0;
         byte_q      <= '0;
         addr_q      <= '0;
         next_addr_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         hold_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         div_q       <= div_d;
         sck_q       <= sck_d;
         cs_n_q      <= cs_n_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
         byte_q      <= byte_d;
         addr_q      <= addr_d;
         next_addr_q <= next_addr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         hold_q      <= hold_d;
      end
   end

   assign ready_o      = (state_q == S_IDLE);
   assign next_addr_o  = next_addr_q;
   assign out_data_o   = data_q;
   assign out_valid_o  = valid_q;
   assign out_last_o   = last_q;
   assign flash_clk_o  = sck_q;
   assign flash_mosi_o = tx_q[31];
   assign flash_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
module tb_spi_flash_burst_reader;
   localparam int SW = 16, CD = 2, BB = 4;
`ifdef SPI_FAST_READ_EN
   localparam int DUMMY = 8;
   localparam logic [7:0] EXP_CMD = 8'h0B;
`else
   localparam int DUMMY = 0;
   localparam logic [7:0] EXP_CMD = 8'h03;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [23:0] start_addr = '0;
   logic        ready, out_valid, out_last, flash_clk, flash_mosi, flash_cs_n;
   logic        out_ready = 1'b0, flash_miso = 1'b0;
   logic [23:0] next_addr;
   logic [7:0]  out_data;
   int          errors = 0, checks = 0;

   spi_flash_burst_reader #(.STARTUP_WAIT(SW), .CLK_DIV(CD), .BURST_BYTES(BB)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_addr_i(start_addr),
      .ready_o(ready), .next_addr_o(next_addr), .out_data_o(out_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
      .flash_clk_o(flash_clk), .flash_mosi_o(flash_mosi), .flash_miso_i(flash_miso),
      .flash_cs_n_o(flash_cs_n));

   always #5 clk = ~clk;

   // Mode-0 flash model: byte at address A reads as A[7:0]^8'h5A.
   int          cs_txn = 0, seen_txn = 0, fbits = 0, fdbit = 0, sck_rises = 0;
   logic [31:0] fsh = '0;
   logic [23:0] faddr = '0, cap_addr = '0;
   logic [7:0]  cap_cmd = '0, mb;
   longint      t_r1 = 0, t_r2 = 0;

   always @(negedge flash_cs_n) cs_txn++;

   always @(posedge flash_clk) if (!flash_cs_n) begin
      if (seen_txn != cs_txn) begin
         seen_txn = cs_txn; fbits = 0; fdbit = 0; sck_rises = 0;
      end
      sck_rises++;
      if (sck_rises == 1) t_r1 = $time;
      if (sck_rises == 2) t_r2 = $time;
      if (fbits < 32) begin
         fsh = {fsh[30:0], flash_mosi};
         fbits++;
         if (fbits == 32) begin
            cap_cmd = fsh[31:24]; cap_addr = fsh[23:0]; faddr = fsh[23:0];
         end
      end else if (fbits < 32 + DUMMY) begin
         fbits++;
      end else begin
         fdbit++;
         if (fdbit == 8) begin fdbit = 0; faddr = faddr + 24'd1; end
      end
   end

   always @(negedge flash_clk) if (!flash_cs_n && fbits == 32 + DUMMY) begin
      mb = faddr[7:0] ^ 8'h5A;
      flash_miso = mb[7 - fdbit];
   end

   typedef struct packed {
      logic [23:0] addr;
      logic [7:0]  stall;   // cycles out_ready held low after first byte
      logic [31:0] bytes;   // expected bytes, first in [31:24]
      logic [23:0] nxt;
   } vec_t;
   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 200) begin @(negedge clk); n++; end
      chk("ready_wait", 32'(ready), 32'd1);
   endtask

   task automatic do_burst(input vec_t v);
      logic [31:0] eb;
      logic [7:0]  got [BB];
      logic [BB-1:0] lst;
      int ngot, cyc, n, r0;
      bit stalled;
      eb = v.bytes; lst = '0; ngot = 0; cyc = 0; stalled = 0;
      wait_ready();
      out_ready = 1'b1;
      start_addr = v.addr; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (ngot < BB && cyc < 2000) begin
         @(negedge clk); cyc++;
         if (out_valid && v.stall != 0 && !stalled) begin
            stalled = 1;
            out_ready = 1'b0;
            repeat (int'(v.stall) - 50) @(negedge clk);
            r0 = sck_rises;
            repeat (50) @(negedge clk);
            chk("stall_sck", 32'(sck_rises), 32'(r0));
            chk("stall_data", 32'(out_data), 32'(eb[31:24]));
            chk("stall_valid", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
         end
         if (out_valid && out_ready) begin
            got[ngot] = out_data; lst[ngot] = out_last; ngot++;
         end
      end
      chk("byte_count", 32'(ngot), 32'(BB));
      for (int i = 0; i < ngot; i++) chk($sformatf("byte%0d", i), 32'(got[i]), 32'(eb[31-8*i -: 8]));
      chk("last_flags", 32'(lst), 32'(1 << (BB-1)));
      n = 0;
      do begin
         @(negedge clk); n++;
         if (n == 1) begin
            chk("done_cs_n", 32'(flash_cs_n), 32'd1);
            chk("done_sck", 32'(flash_clk), 32'd0);
         end
      end while (!ready && n < 100);
      chk("cs_hold", 32'(n >= 2*CD + 1), 32'd1);
      chk("next_addr", 32'(next_addr), 32'(v.nxt));
      chk("cmd", 32'(cap_cmd), 32'(EXP_CMD));
      chk("addr", 32'(cap_addr), 32'(v.addr));
      chk("sck_rises", 32'(sck_rises), 32'(32 + DUMMY + 8*BB));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cs_low, cyc;
      vecs[0] = '{24'h000100, 8'd0,   32'h5A5B5859, 24'h000104};
      vecs[1] = '{24'h000100, 8'd100, 32'h5A5B5859, 24'h000104};
      vecs[2] = '{24'hFFFFFE, 8'd0,   32'hA4A55A5B, 24'h000002};
      vecs[3] = '{24'h0000F0, 8'd0,   32'hAAABA8A9, 24'h0000F4};

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cs_n", 32'(flash_cs_n), 32'd1);
      chk("rst_sck", 32'(flash_clk), 32'd0);
      chk("rst_mosi", 32'(flash_mosi), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_next", 32'(next_addr), 32'd0);

      // Startup wait; a start during INIT must be ignored.
      rst_n = 1'b1; cs_low = 0; start_addr = 24'h000100;
      for (int i = 1; i <= SW; i++) begin
         start = (i == 5);
         @(negedge clk);
         if (!flash_cs_n) cs_low++;
         if (i == SW-1) chk("init_ready_low", 32'(ready), 32'd0);
      end
      start = 1'b0;
      chk("init_ready_high", 32'(ready), 32'd1);
      repeat (5) begin
         @(negedge clk);
         if (!flash_cs_n) cs_low++;
      end
      chk("init_cs_idle", 32'(cs_low), 32'd0);

      // Table-driven bursts
      for (int i = 0; i < 4; i++) begin
         do_burst(vecs[i]);
         if (i == 0) chk("sck_period", 32'(t_r2 - t_r1), 32'(2*CD*10));
      end

      // Reset during the second data byte
      wait_ready();
      out_ready = 1'b1; start_addr = 24'h000100; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 0;
      while (sck_rises < 32 + DUMMY + 8 + 3 && cyc < 1000) begin @(negedge clk); cyc++; end
      chk("abort_reach", 32'(cyc < 1000), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_cs_n", 32'(flash_cs_n), 32'd1);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_sck", 32'(flash_clk), 32'd0);
      rst_n = 1'b1;
      do_burst(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
